// File: rtl/player_input_ctrl.sv
// ---------------------------------------------------------------------------
// player_input_ctrl
//
// Producer side of the player-input memory-mapped interface. Four raw player
// buttons are synchronised, debounced and edge-detected; after the CPU arms a
// round, the first press wins. The winner and its reaction time are held until
// the CPU acknowledges them.
//
// Ports:
//   clk              system clock, all state on rising edge
//   rst              synchronous, active-high reset
//   btn[3:0]         raw asynchronous buttons, active-high, bit i = player i+1
//   arm              one-cycle pulse: start a round
//   ack              one-cycle pulse: consume the result / abort the round
//   playerInputFlag  high while a winning press is held (LOCKED)
//   playerId         winning player 1..4, zero-extended; 0 when none yet
//   reactionTime     ARMED cycles elapsed before the win, saturating
//   armed            high while a round is armed and no winner yet
// ---------------------------------------------------------------------------
module player_input_ctrl #(
   parameter int WIDTH    = 16,
   parameter int DB_COUNT = 250000,
   parameter int DB_BITS  = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       btn,
   input  logic             arm,
   input  logic             ack,
   output logic             playerInputFlag,
   output logic [WIDTH-1:0] playerId,
   output logic [WIDTH-1:0] reactionTime,
   output logic             armed
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [DB_BITS-1:0] DB_LAST = DB_BITS'(DB_COUNT - 1);

   logic [3:0]         sync_p1;
   logic [3:0]         sync_p2;
   logic [3:0]         stable;
   logic [3:0]         stable_d;
   logic [DB_BITS-1:0] db_cnt [4];
   logic [3:0]         rise;
   logic [WIDTH-1:0]   timer;
   state_t             state;

   // Player number of the lowest-index set bit; simultaneous presses resolve
   // in favour of the lower player number.
   function automatic logic [2:0] first_player(input logic [3:0] r);
      logic [2:0] id;
      id = 3'd0;
      for (int i = 3; i >= 0; i--) begin
         if (r[i]) id = 3'(i + 1);
      end
      return id;
   endfunction

   // Reaction timer sticks at all-ones rather than wrapping to a tiny value.
   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] t);
      return (&t) ? t : t + 1'b1;
   endfunction

   // --- stage p1/p2: two-flop synchroniser, then per-button debounce ---
   // The debounced level only moves after DB_COUNT consecutive cycles of
   // disagreement with the synchronised input; any agreement restarts the run.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p1  <= '0;
         sync_p2  <= '0;
         stable   <= '0;
         stable_d <= '0;
         for (int i = 0; i < 4; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync_p1  <= btn;
         sync_p2  <= sync_p1;
         stable_d <= stable;
         for (int i = 0; i < 4; i++) begin
            if (sync_p2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= sync_p2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // A press is a fresh 0->1 of the debounced level, so a button already held
   // when the round is armed never counts until it is released and re-pressed.
   assign rise = stable & ~stable_d;

   // --- stage fsm: arbitration and result hold, all outputs registered ---
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         playerInputFlag <= 1'b0;
         playerId        <= '0;
         reactionTime    <= '0;
         armed           <= 1'b0;
         timer           <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (arm) begin
                  state <= ARMED;
                  armed <= 1'b1;
                  timer <= '0;
               end
            end
            ARMED: begin
               // ack aborts the round even if a press lands in the same cycle
               if (ack) begin
                  state <= IDLE;
                  armed <= 1'b0;
               end else if (|rise) begin
                  state           <= LOCKED;
                  armed           <= 1'b0;
                  playerInputFlag <= 1'b1;
                  playerId        <= WIDTH'(first_player(rise));
                  reactionTime    <= timer;
               end else begin
                  timer <= sat_inc(timer);
               end
            end
            LOCKED: begin
               // playerId/reactionTime stay visible until the next win
               if (ack) begin
                  state           <= IDLE;
                  playerInputFlag <= 1'b0;
               end
            end
            default: begin
               state           <= IDLE;
               playerInputFlag <= 1'b0;
               armed           <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_player_input_ctrl.sv
module tb_player_input_ctrl;

   localparam int DBC = 4;
   localparam int S_IDLE = 0, S_ARMED = 1, S_LOCKED = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  btn = 4'b0;
   logic        arm = 1'b0;
   logic        ack = 1'b0;
   logic        playerInputFlag;
   logic [15:0] playerId;
   logic [15:0] reactionTime;
   logic        armed;

   int chk = 0;
   int err = 0;

   player_input_ctrl #(.WIDTH(16), .DB_COUNT(DBC), .DB_BITS(4)) dut (
      .clk(clk), .rst(rst), .btn(btn), .arm(arm), .ack(ack),
      .playerInputFlag(playerInputFlag), .playerId(playerId),
      .reactionTime(reactionTime), .armed(armed)
   );

   always #5 clk = ~clk;

   // Reference model: input seen by the debouncer is the raw button two edges
   // late; a debounced level flips once the last DBC inputs all disagree with it.
   logic [3:0]  m_raw[$];
   logic [3:0]  m_din[$];
   logic [3:0]  m_stable, m_stable_d;
   int          m_state;
   logic        m_flag, m_armed;
   logic [15:0] m_id, m_rt, m_timer;

   always @(posedge clk) begin : model
      logic [3:0] din, rise, nstab;
      logic all_diff, found;
      if (rst) begin
         m_raw.delete(); m_din.delete();
         m_stable = '0; m_stable_d = '0;
         m_state = S_IDLE; m_flag = 1'b0; m_armed = 1'b0;
         m_id = '0; m_rt = '0; m_timer = '0;
      end else begin
         din = (m_raw.size() >= 2) ? m_raw[m_raw.size()-2] : 4'b0;
         m_raw.push_back(btn);
         if (m_raw.size() > 2) void'(m_raw.pop_front());
         rise = m_stable & ~m_stable_d;
         case (m_state)
            S_IDLE: if (arm) begin m_state = S_ARMED; m_timer = 0; end
            S_ARMED: begin
               if (ack) m_state = S_IDLE;
               else if (rise != 0) begin
                  m_state = S_LOCKED; m_flag = 1'b1; m_rt = m_timer;
                  found = 1'b0;
                  for (int i = 0; i < 4; i++)
                     if (rise[i] && !found) begin m_id = 16'(i + 1); found = 1'b1; end
               end else if (m_timer != 16'hFFFF) m_timer = m_timer + 16'd1;
            end
            default: if (ack) begin m_state = S_IDLE; m_flag = 1'b0; end
         endcase
         m_armed = (m_state == S_ARMED);
         m_din.push_back(din);
         if (m_din.size() > DBC) void'(m_din.pop_front());
         nstab = m_stable;
         if (m_din.size() == DBC) begin
            for (int i = 0; i < 4; i++) begin
               all_diff = 1'b1;
               foreach (m_din[j]) if (m_din[j][i] == m_stable[i]) all_diff = 1'b0;
               if (all_diff) nstab[i] = ~m_stable[i];
            end
         end
         m_stable_d = m_stable;
         m_stable   = nstab;
      end
   end

   task automatic cyc(input logic [3:0] b, input logic a, input logic k, input logic r);
      @(negedge clk);
      btn = b; arm = a; ack = k; rst = r;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      for (int n = 0; n < 3; n++) cyc(4'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      chk++; if ({playerInputFlag, armed} !== 2'b00) begin err++;
         $display("FAIL reset_ctrl got flag/armed %b want 00", {playerInputFlag, armed}); end
      chk++; if (playerId !== 16'h0) begin err++;
         $display("FAIL reset_id got %h want 0000", playerId); end
      chk++; if (reactionTime !== 16'h0) begin err++;
         $display("FAIL reset_rt got %h want 0000", reactionTime); end
      for (int n = 0; n < 8; n++) cyc(4'b0, 1'b0, 1'b0, 1'b0);
      chk++; if ({playerInputFlag, playerId, reactionTime, armed} !== {m_flag, m_id, m_rt, m_armed}) begin err++;
         $display("FAIL reset_model got %h want %h", {playerInputFlag, playerId, reactionTime, armed}, {m_flag, m_id, m_rt, m_armed}); end
   endtask

   task automatic test_basic_win;
      cyc(4'b0, 1'b1, 1'b0, 1'b0);
      chk++; if (armed !== 1'b1) begin err++;
         $display("FAIL basic_armed got %b want 1", armed); end
      for (int e = 1; e <= 7; e++) begin
         cyc(4'b0010, 1'b0, 1'b0, 1'b0);
         chk++; if (playerInputFlag !== (e >= 7)) begin err++;
            $display("FAIL basic_flag_edge%0d got %b want %b", e, playerInputFlag, (e >= 7)); end
         chk++; if ({playerInputFlag, playerId, reactionTime, armed} !== {m_flag, m_id, m_rt, m_armed}) begin err++;
            $display("FAIL basic_model got %h want %h", {playerInputFlag, playerId, reactionTime, armed}, {m_flag, m_id, m_rt, m_armed}); end
      end
      chk++; if (playerId !== 16'd2) begin err++;
         $display("FAIL basic_id got %0d want 2", playerId); end
      chk++; if (reactionTime !== 16'd6) begin err++;
         $display("FAIL basic_rt got %0d want 6", reactionTime); end
      cyc(4'b0010, 1'b0, 1'b1, 1'b0);
      chk++; if ({playerInputFlag, armed, playerId} !== {2'b00, 16'd2}) begin err++;
         $display("FAIL ack_locked got flag=%b armed=%b id=%0d want 0 0 2", playerInputFlag, armed, playerId); end
      for (int n = 0; n < 8; n++) cyc(4'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_simultaneous;
      cyc(4'b0, 1'b1, 1'b0, 1'b0);
      for (int n = 0; n < int'($urandom_range(5, 1)); n++) cyc(4'b0, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 8; n++) cyc(4'b1010, 1'b0, 1'b0, 1'b0);
      chk++; if ({playerInputFlag, playerId} !== {1'b1, 16'd2}) begin err++;
         $display("FAIL simul_win got flag=%b id=%0d want 1 2", playerInputFlag, playerId); end
      for (int n = 0; n < 8; n++) begin
         cyc(4'b1011, 1'b0, 1'b0, 1'b0);
         chk++; if ({playerInputFlag, playerId, reactionTime, armed} !== {m_flag, m_id, m_rt, m_armed}) begin err++;
            $display("FAIL simul_model got %h want %h", {playerInputFlag, playerId, reactionTime, armed}, {m_flag, m_id, m_rt, m_armed}); end
      end
      chk++; if (playerId !== 16'd2) begin err++;
         $display("FAIL simul_late_press got id=%0d want 2", playerId); end
      cyc(4'b0, 1'b0, 1'b1, 1'b0);
      for (int n = 0; n < 8; n++) cyc(4'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_glitch;
      cyc(4'b0, 1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 3; n++) cyc(4'b0001, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 6; n++) cyc(4'b0000, 1'b0, 1'b0, 1'b0);
      chk++; if ({playerInputFlag, armed} !== 2'b01) begin err++;
         $display("FAIL glitch_ignored got flag/armed %b want 01", {playerInputFlag, armed}); end
      for (int n = 0; n < 10; n++) begin
         cyc(4'b0001, 1'b0, 1'b0, 1'b0);
         chk++; if ({playerInputFlag, playerId, reactionTime, armed} !== {m_flag, m_id, m_rt, m_armed}) begin err++;
            $display("FAIL glitch_model got %h want %h", {playerInputFlag, playerId, reactionTime, armed}, {m_flag, m_id, m_rt, m_armed}); end
      end
      chk++; if ({playerInputFlag, playerId} !== {1'b1, 16'd1}) begin err++;
         $display("FAIL glitch_win got flag=%b id=%0d want 1 1", playerInputFlag, playerId); end
      cyc(4'b0, 1'b0, 1'b1, 1'b0);
      for (int n = 0; n < 8; n++) cyc(4'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_held_before_arm;
      for (int n = 0; n < 10; n++) cyc(4'b0100, 1'b0, 1'b0, 1'b0);
      cyc(4'b0100, 1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 20; n++) begin
         cyc(4'b0100, 1'b0, 1'b0, 1'b0);
         chk++; if (playerInputFlag !== 1'b0) begin err++;
            $display("FAIL held_no_win got flag=%b want 0", playerInputFlag); end
      end
      for (int n = 0; n < 8; n++) cyc(4'b0000, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 8; n++) cyc(4'b0100, 1'b0, 1'b0, 1'b0);
      chk++; if ({playerInputFlag, playerId} !== {1'b1, 16'd3}) begin err++;
         $display("FAIL held_repress got flag=%b id=%0d want 1 3", playerInputFlag, playerId); end
      cyc(4'b0, 1'b0, 1'b1, 1'b0);
      for (int n = 0; n < 8; n++) cyc(4'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_saturate;
      cyc(4'b0, 1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 70000; n++) begin
         cyc(4'b0, 1'b0, 1'b0, 1'b0);
         chk++; if ({playerInputFlag, playerId, reactionTime, armed} !== {m_flag, m_id, m_rt, m_armed}) begin err++;
            $display("FAIL sat_model got %h want %h", {playerInputFlag, playerId, reactionTime, armed}, {m_flag, m_id, m_rt, m_armed}); end
      end
      for (int n = 0; n < 8; n++) cyc(4'b0001, 1'b0, 1'b0, 1'b0);
      chk++; if ({playerInputFlag, playerId, reactionTime} !== {1'b1, 16'd1, 16'hFFFF}) begin err++;
         $display("FAIL sat_rt got flag=%b id=%0d rt=%h want 1 1 ffff", playerInputFlag, playerId, reactionTime); end
      cyc(4'b0, 1'b0, 1'b1, 1'b0);
      for (int n = 0; n < 8; n++) cyc(4'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_handshakes;
      cyc(4'b0, 1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 5; n++) cyc(4'b0, 1'b0, 1'b0, 1'b0);
      cyc(4'b0, 1'b0, 1'b1, 1'b0);
      chk++; if ({playerInputFlag, armed, playerId, reactionTime} !== {2'b00, 16'd1, 16'hFFFF}) begin err++;
         $display("FAIL ack_armed got %h want %h", {playerInputFlag, armed, playerId, reactionTime}, {2'b00, 16'd1, 16'hFFFF}); end
      cyc(4'b0, 1'b1, 1'b1, 1'b0);
      chk++; if (armed !== 1'b1) begin err++;
         $display("FAIL arm_ack_idle got armed=%b want 1", armed); end
      cyc(4'b0, 1'b0, 1'b0, 1'b1);
      chk++; if ({playerInputFlag, armed, playerId, reactionTime} !== 34'h0) begin err++;
         $display("FAIL rst_armed got %h want 0", {playerInputFlag, armed, playerId, reactionTime}); end
      cyc(4'b0, 1'b1, 1'b0, 1'b0);
      for (int n = 0; n < 7; n++) cyc(4'b1000, 1'b0, 1'b0, 1'b0);
      chk++; if ({playerInputFlag, playerId} !== {1'b1, 16'd4}) begin err++;
         $display("FAIL hs_win got flag=%b id=%0d want 1 4", playerInputFlag, playerId); end
      cyc(4'b1000, 1'b1, 1'b0, 1'b0);
      chk++; if ({playerInputFlag, armed} !== 2'b10) begin err++;
         $display("FAIL arm_locked got flag/armed %b want 10", {playerInputFlag, armed}); end
      cyc(4'b1000, 1'b1, 1'b1, 1'b0);
      chk++; if ({playerInputFlag, armed, playerId} !== {2'b00, 16'd4}) begin err++;
         $display("FAIL arm_ack_locked got %h want %h", {playerInputFlag, armed, playerId}, {2'b00, 16'd4}); end
      for (int n = 0; n < 8; n++) cyc(4'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_random;
      logic [3:0] b;
      b = 4'b0;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(5, 0) == 0) b[$urandom_range(3, 0)] = ~b[$urandom_range(3, 0)];
         cyc(b, ($urandom_range(19, 0) == 0), ($urandom_range(29, 0) == 0), ($urandom_range(499, 0) == 0));
         chk++; if ({playerInputFlag, playerId, reactionTime, armed} !== {m_flag, m_id, m_rt, m_armed}) begin err++;
            $display("FAIL random_model cycle %0d got %h want %h", n, {playerInputFlag, playerId, reactionTime, armed}, {m_flag, m_id, m_rt, m_armed}); end
      end
   endtask

   initial begin
      test_reset();
      test_basic_win();
      test_simultaneous();
      test_glitch();
      test_held_before_arm();
      test_saturate();
      test_handshakes();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end

endmodule
